mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised N-channel, W-bit registered multiplexer with manual and auto-scan modes, the sequential successor to the lab's fixed 2:1/4:1/8:1 mux trees. In manual mode it forwards the channel chosen by `sel`. In scan mode an internal dwell counter steps through all channels in round-robin order, as needed for time-multiplexed displays and input scanners. Output data, current channel index and change/frame strobes are all registered.

## Interface

Parameters:

- `N`, 8: number of channels, 2..64, not required to be a power of two.
- `W`, 1: data width per channel, ≥1.
- `DWELL`, 4: clock cycles spent on each channel in scan mode, 1..65535.
- Derived, not overridable:
  - `SW` = max(1, clog2(N)): channel index width.
  - `DW` = max(1, clog2(DWELL)): dwell counter width.

Ports:

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately, independent of `clk`.
- `data`  in  N*W  flattened channel inputs; channel i occupies bits [i*W +: W].
- `sel`  in  SW  manual channel select; values ≥ N clamp to N-1.
- `mode`  in  1  0 = manual, 1 = scan.
- `en`  in  1  scan advance enable; ignored in manual mode.
- `y`  out  W  registered selected data.
- `ch`  out  SW  registered current channel index.
- `chg`  out  1  one-cycle pulse, high in the cycle `ch` holds a value different from the previous cycle.
- `frame`  out  1  one-cycle pulse, high in the cycle a scan wrap N-1→0 takes effect.

## Operation

- FSM states, decided combinationally from the inputs and registered:
  - MANUAL: `mode`=0.
  - SCAN: `mode`=1, `en`=1.
  - PAUSE: `mode`=1, `en`=0.
- Next channel `ch_n` per state:
  - MANUAL: `ch_n` = clamp(`sel`). Dwell counter `dc` is cleared to 0.
  - SCAN with `dc` = DWELL-1: `dc` ← 0; `ch_n` = (`ch` = N-1) ? 0 : `ch`+1.
  - SCAN otherwise: `dc` ← `dc`+1; `ch_n` = `ch`.
  - PAUSE: `ch_n` = `ch`; `dc` held.
- Every edge:
  - `ch` ← `ch_n`.
  - `y` ← data slice [`ch_n`*W +: W]. `y` always tracks the live data of the current channel, including in PAUSE.
  - `chg` ← (`ch_n` ≠ `ch`).
  - `frame` ← 1 only when the SCAN wrap branch fires. A manual selection of 0 never asserts `frame`.
- Transitions:
  - MANUAL→SCAN: scanning starts at the current `ch`, with `dc`=0. That channel gets a full DWELL cycles.
  - SCAN/PAUSE→MANUAL: `ch` jumps to clamp(`sel`) on the next edge.
  - PAUSE→SCAN: resumes with the held `dc`. No cycles are lost or added.
- DWELL=1: `ch` advances every SCAN cycle; `dc` is constant 0.
- N=2: `ch` toggles 0,1,0,1; `frame` asserts on every return to 0.
- Counter arithmetic is unsigned and modulo only via the explicit compare/reset above. There is no free-running overflow.

## Timing

- Latency is 1 cycle from `data`, `sel`, `mode` and `en` to `y`, `ch`, `chg` and `frame`. There is no combinational path from input to output.
- Scan period:
  - One channel step every DWELL SCAN cycles.
  - A full frame takes N*DWELL SCAN cycles.
  - PAUSE cycles are excluded from both counts.
- Reset values, held while `reset`=1 and for the first edge after release: state MANUAL, `ch`=0, `dc`=0, `y`=0, `chg`=0, `frame`=0.
- Reset asserted mid-scan clears everything asynchronously. After release, the first edge behaves as from power-up. With `mode`=1 at release, scanning starts at channel 0.
- `chg` and `frame` are never high during reset. `chg` is not asserted by reset itself.

## Test plan

- Manual select: N=8, W=4, data[i]=i+3, `mode`=0, `sel`=5 → next edge `y`=8, `ch`=5, `chg`=1; `chg`=0 on the following cycle with `sel` unchanged.
- Clamp: N=6, `sel`=7 → `ch`=5, `y`=data[5].
- Scan: N=4, DWELL=3, `mode`=1, `en`=1 from `ch`=0 → `ch` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; `chg` high on each step; `frame` high only with the final 0.
- Pause/resume: N=4, DWELL=3. Drop `en` after 2 cycles on channel 1 and hold 5 cycles → `ch` stays 1 and `y` follows live data[1]. After `en` returns, `ch` becomes 2 after exactly 1 more cycle.
- Mode switch: scanning at `ch`=2, set `mode`=0 with `sel`=6 → next edge `ch`=6, `frame`=0. Return to `mode`=1 → channel 6 dwells a full DWELL cycles, then 7, then wrap to 0 with `frame`=1.
- Async reset: assert `reset` mid-dwell between edges → outputs go to 0 immediately, before the next edge. After release with `mode`=1, DWELL=1 → `ch` sequence 0,1,2,…

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit registered multiplexer.
// In manual mode it forwards the channel picked by sel, clamped to N-1.
// In scan mode a dwell counter steps through the channels round-robin.
// All outputs are registered, so there is no combinational input-to-output path.
module mux_scan #(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SW    = (N > 2) ? $clog2(N) : 1,
  localparam int DW    = (DWELL > 2) ? $clog2(DWELL) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  data,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            chg,
  output logic            frame
);

  localparam logic [SW-1:0] CH_LAST = SW'(N - 1);
  localparam logic [DW-1:0] DC_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_n;
  logic [DW-1:0]   dc;
  logic [DW-1:0]   dc_n;
  logic [DW-1:0]   dc_cur;
  logic [SW-1:0]   sel_c;
  logic [SW-1:0]   ch_n;
  logic            frame_n;

  // Decode the mode, then compute the next channel, dwell count and wrap strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_n = MANUAL;
    ch_n    = ch;
    dc_n    = dc;
    frame_n = 1'b0;
    sel_c   = (sel > CH_LAST) ? CH_LAST : sel;
    // A scan entered straight from MANUAL always begins a fresh dwell.
    dc_cur  = (state_q == MANUAL) ? '0 : dc;

    if (mode) begin
      state_n = en ? SCAN : PAUSE;
    end

    case (state_n)
      MANUAL: begin
        ch_n = sel_c;
        dc_n = '0;
      end
      SCAN: begin
        if (dc_cur == DC_LAST) begin
          dc_n = '0;
          if (ch == CH_LAST) begin
            ch_n    = '0;
            frame_n = 1'b1;
          end else begin
            ch_n = ch + 1'b1;
          end
        end else begin
          dc_n = dc_cur + 1'b1;
        end
      end
      PAUSE: begin
        // Channel and dwell count hold; y still tracks the live data below.
        ch_n = ch;
        dc_n = dc;
      end
      default: begin
        ch_n = sel_c;
        dc_n = '0;
      end
    endcase
  end

  // Register state, channel, data and strobes; reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= MANUAL;
      ch      <= '0;
      dc      <= '0;
      y       <= '0;
      chg     <= 1'b0;
      frame   <= 1'b0;
    end else begin
      state_q <= state_n;
      ch      <= ch_n;
      dc      <= dc_n;
      y       <= data[int'(ch_n) * W +: W];
      chg     <= (ch_n != ch);
      frame   <= frame_n;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: the driver applies directed vectors and
// queues the hand-computed response; per-DUT monitors pop and compare once
// per clock, one time unit after the rising edge.
`timescale 1ns/1ps
module tb_mux_scan;

  typedef struct packed {
    logic       mode;
    logic       en;
    logic [2:0] sel;
    logic [2:0] ch;
    logic       chg;
    logic       frame;
  } vec_t;

  typedef struct packed {
    logic [3:0] y;
    logic [2:0] ch;
    logic       chg;
    logic       frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  // Instance A: N=8, W=4, DWELL=3.
  logic [31:0] data_a;
  logic [2:0]  sel_a = '0;
  logic        mode_a = 1'b0;
  logic        en_a = 1'b0;
  logic [3:0]  y_a;
  logic [2:0]  ch_a;
  logic        chg_a;
  logic        frame_a;

  // Instance B: N=6, W=4, DWELL=1.
  logic [23:0] data_b;
  logic [2:0]  sel_b = '0;
  logic        mode_b = 1'b0;
  logic        en_b = 1'b0;
  logic [3:0]  y_b;
  logic [2:0]  ch_b;
  logic        chg_b;
  logic        frame_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_total = 0;
  int   n_pass  = 0;

  vec_t tbl_a[26];
  vec_t tbl_b[9];
  vec_t rst_a[6];
  vec_t rst_b[6];

  mux_scan #(.N(8), .W(4), .DWELL(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .data  (data_a),
    .sel   (sel_a),
    .mode  (mode_a),
    .en    (en_a),
    .y     (y_a),
    .ch    (ch_a),
    .chg   (chg_a),
    .frame (frame_a)
  );

  mux_scan #(.N(6), .W(4), .DWELL(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .data  (data_b),
    .sel   (sel_b),
    .mode  (mode_b),
    .en    (en_b),
    .y     (y_b),
    .ch    (ch_b),
    .chg   (chg_b),
    .frame (frame_b)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic m, input logic e, input logic [2:0] s,
                              input logic [2:0] c, input logic cg, input logic f);
    vec_t v;
    v.mode = m; v.en = e; v.sel = s; v.ch = c; v.chg = cg; v.frame = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Apply one cycle of stimulus at the falling edge and queue the response
  // expected after the following rising edge. d1 is the live value of A's channel 1.
  task automatic step(input vec_t a, input bit use_a, input vec_t b, input bit use_b,
                      input logic [3:0] d1);
    @(negedge clk);
    data_a[7:4] = d1;
    if (use_a) begin
      mode_a = a.mode; en_a = a.en; sel_a = a.sel;
      q_a.push_back('{y: data_a[a.ch*4 +: 4], ch: a.ch, chg: a.chg, frame: a.frame});
    end
    if (use_b) begin
      mode_b = b.mode; en_b = b.en; sel_b = b.sel;
      q_b.push_back('{y: data_b[b.ch*4 +: 4], ch: b.ch, chg: b.chg, frame: b.frame});
    end
  endtask

  // Monitor A.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_y",     32'(y_a),     32'(e.y));
      check("a_ch",    32'(ch_a),    32'(e.ch));
      check("a_chg",   32'(chg_a),   32'(e.chg));
      check("a_frame", 32'(frame_a), 32'(e.frame));
    end
  end

  // Monitor B.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_y",     32'(y_b),     32'(e.y));
      check("b_ch",    32'(ch_b),    32'(e.ch));
      check("b_chg",   32'(chg_b),   32'(e.chg));
      check("b_frame", 32'(frame_b), 32'(e.frame));
    end
  end

  initial begin
    logic [3:0] d1;
    for (int i = 0; i < 8; i++) data_a[i*4 +: 4] = 4'(i + 3);
    for (int i = 0; i < 6; i++) data_b[i*4 +: 4] = 4'(2 * i + 1);

    // A: manual, pause/resume, manual interrupt of a scan, wrap.
    tbl_a = '{
      mk(0,0,5, 5,1,0), mk(0,0,5, 5,0,0), mk(0,0,0, 0,1,0),
      mk(1,1,0, 0,0,0), mk(1,1,0, 0,0,0), mk(1,1,0, 1,1,0),
      mk(1,1,0, 1,0,0), mk(1,1,0, 1,0,0),
      mk(1,0,0, 1,0,0), mk(1,0,0, 1,0,0), mk(1,0,0, 1,0,0),
      mk(1,0,0, 1,0,0), mk(1,0,0, 1,0,0),
      mk(1,1,0, 2,1,0), mk(1,1,0, 2,0,0), mk(0,1,6, 6,1,0),
      mk(1,1,0, 6,0,0), mk(1,1,0, 6,0,0), mk(1,1,0, 7,1,0),
      mk(1,1,0, 7,0,0), mk(1,1,0, 7,0,0), mk(1,1,0, 0,1,1),
      mk(1,1,0, 0,0,0), mk(1,1,0, 0,0,0), mk(1,1,0, 1,1,0),
      mk(1,1,0, 1,0,0)
    };
    // B: clamp of out-of-range sel, DWELL=1 stepping, N=6 wrap, pause.
    tbl_b = '{
      mk(0,0,7, 5,1,0), mk(0,0,6, 5,0,0), mk(0,0,2, 2,1,0),
      mk(1,1,0, 3,1,0), mk(1,1,0, 4,1,0), mk(1,1,0, 5,1,0),
      mk(1,1,0, 0,1,1), mk(1,1,0, 1,1,0), mk(1,0,0, 1,0,0)
    };
    // After reset release with mode=1, en=1.
    rst_a = '{
      mk(1,1,0, 0,0,0), mk(1,1,0, 0,0,0), mk(1,1,0, 1,1,0),
      mk(1,1,0, 1,0,0), mk(1,1,0, 1,0,0), mk(1,1,0, 2,1,0)
    };
    rst_b = '{
      mk(1,1,0, 1,1,0), mk(1,1,0, 2,1,0), mk(1,1,0, 3,1,0),
      mk(1,1,0, 4,1,0), mk(1,1,0, 5,1,0), mk(1,1,0, 0,1,1)
    };

    // Reset state, immediately and held across edges.
    #1 reset = 1'b1;
    #1;
    check("rst_a_y",     32'(y_a),     32'h0);
    check("rst_a_ch",    32'(ch_a),    32'h0);
    check("rst_a_chg",   32'(chg_a),   32'h0);
    check("rst_a_frame", 32'(frame_a), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_a_ch", 32'(ch_a), 32'h0);
    check("rst_held_b_ch", 32'(ch_b), 32'h0);
    #1 reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      if (i == 9 || i == 10) d1 = 4'hE;
      else if (i == 11 || i == 12) d1 = 4'h5;
      else d1 = 4'h4;
      step(tbl_a[i], 1'b1, tbl_b[i < 9 ? i : 0], i < 9, d1);
    end

    // Async reset between edges, mid-dwell on A (channel 1) and paused B.
    @(posedge clk);
    #2 reset = 1'b1;
    mode_a = 1'b1; en_a = 1'b1;
    mode_b = 1'b1; en_b = 1'b1;
    #1;
    check("async_a_y",     32'(y_a),     32'h0);
    check("async_a_ch",    32'(ch_a),    32'h0);
    check("async_a_chg",   32'(chg_a),   32'h0);
    check("async_a_frame", 32'(frame_a), 32'h0);
    check("async_b_y",     32'(y_b),     32'h0);
    check("async_b_ch",    32'(ch_b),    32'h0);
    @(posedge clk);
    #1;
    check("async_held_a_ch",  32'(ch_a),  32'h0);
    check("async_held_b_chg", 32'(chg_b), 32'h0);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) step(rst_a[i], 1'b1, rst_b[i], 1'b1, 4'h4);

    // Let the monitors drain the queues, bounded.
    for (int k = 0; k < 4 && (q_a.size() > 0 || q_b.size() > 0); k++) @(posedge clk);
    #2;
    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
